// File: rtl/fetch_unit.sv
// Instruction fetch / PC stage: FETCH -> LOAD -> EXEC, one exec_valid cycle per instruction.
// Optional jump-to-self halt detection is enabled by defining FETCH_HALT_DETECT_EN.
module fetch_unit #(
    parameter logic [7:0]  RESET_PC = 8'h00,
    parameter int unsigned INSTR_W  = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               sel_pc,
    input  logic               sel_br,
    input  logic [7:0]         pc_in,
    output logic [7:0]         rom_addr,
    output logic [3:0]         opcode,
    output logic [7:0]         k,
    output logic [7:0]         pc,
    output logic               exec_valid,
    output logic               halted
);

    localparam int unsigned OP_W = 4;
    localparam int unsigned K_W  = 8;
    localparam logic [OP_W-1:0] OP_JUMP = 4'b0110;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_LOAD  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               exec_valid_q, exec_valid_d;
    logic               halted_q, halted_d;
    logic               halt_hit_c;

`ifdef FETCH_HALT_DETECT_EN
    assign halt_hit_c = (state_q == ST_EXEC)
                      && (ir_q[INSTR_W-1 -: OP_W] == OP_JUMP)
                      && (ir_q[K_W-1:0] == pc_q);
`else
    assign halt_hit_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: if (run) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_EXEC;
            ST_EXEC:  state_d = halt_hit_c ? ST_HALT : ST_FETCH;
`ifdef FETCH_HALT_DETECT_EN
            ST_HALT:  state_d = ST_HALT;
`endif
            default:  state_d = ST_FETCH;
        endcase
    end

    // IR capture, next-PC selection (jump > skip > increment) and registered flags.
    always_comb begin
        pc_d         = pc_q;
        ir_d         = ir_q;
        exec_valid_d = (state_d == ST_EXEC);
`ifdef FETCH_HALT_DETECT_EN
        halted_d     = halted_q | (state_d == ST_HALT);
`else
        halted_d     = 1'b0;
`endif
        if (state_q == ST_LOAD) begin
            ir_d = rom_data;
        end
        if ((state_q == ST_EXEC) && !halt_hit_c) begin
            if (sel_pc) begin
                pc_d = pc_in;
            end else if (sel_br) begin
                pc_d = pc_q + 8'd2;
            end else begin
                pc_d = pc_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            ir_q         <= '0;
            exec_valid_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            exec_valid_q <= exec_valid_d;
            halted_q     <= halted_d;
        end
    end

    assign rom_addr   = pc_q;
    assign pc         = pc_q;
    assign opcode     = ir_q[INSTR_W-1 -: OP_W];
    assign k          = ir_q[K_W-1:0];
    assign exec_valid = exec_valid_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed sequences, a next-PC vector table and
// a randomized run against an instruction-level reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [11:0] rom_data;
    logic        sel_pc;
    logic        sel_br;
    logic [7:0]  pc_in;
    logic [7:0]  rom_addr;
    logic [3:0]  opcode;
    logic [7:0]  k;
    logic [7:0]  pc;
    logic        exec_valid;
    logic        halted;

    logic [11:0] rom [256];
    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0] start;
        logic       sp;
        logic       sb;
        logic [7:0] pin;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [10];

    fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .rom_data   (rom_data),
        .sel_pc     (sel_pc),
        .sel_br     (sel_br),
        .pc_in      (pc_in),
        .rom_addr   (rom_addr),
        .opcode     (opcode),
        .k          (k),
        .pc         (pc),
        .exec_valid (exec_valid),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // Synchronous program ROM: data valid one cycle after the address.
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset(input bit check);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        if (check) begin
            chk("rst_pc", 32'(pc), 32'h00);
            chk("rst_rom_addr", 32'(rom_addr), 32'h00);
            chk("rst_opcode", 32'(opcode), 32'h0);
            chk("rst_k", 32'(k), 32'h00);
            chk("rst_exec_valid", 32'(exec_valid), 32'h0);
            chk("rst_halted", 32'(halted), 32'h0);
        end
        rst = 1'b0;
    endtask

    task automatic wait_exec();
        bit seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            if (exec_valid === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL wait_exec: got no exec_valid within 6 cycles expected a pulse");
        end
    endtask

    // Reset, then let the first instruction jump to target; returns in the FETCH cycle at target.
    task automatic goto_pc(input logic [7:0] target);
        run = 1'b1;
        do_reset(1'b0);
        wait_exec();
        sel_pc = 1'b1;
        pc_in  = target;
        @(negedge clk);
        sel_pc = 1'b0;
        sel_br = 1'b0;
        pc_in  = 8'h00;
    endtask

    initial begin
        logic [7:0]  model_pc;
        logic [7:0]  nxt;
        logic [31:0] r;
        logic [3:0]  op;
        bit          ev;

        rst = 1'b1; run = 1'b1; sel_pc = 1'b0; sel_br = 1'b0; pc_in = 8'h00;
        for (int i = 0; i < 256; i++) rom[i] = {4'hA, 8'(i)};
        rom[0] = 12'hF05; rom[1] = 12'h103; rom[2] = 12'h502;
        rom[9] = 12'h609;

        vecs[0] = '{start: 8'h10, sp: 1'b1, sb: 1'b0, pin: 8'h40, exp: 8'h40};
        vecs[1] = '{start: 8'h40, sp: 1'b0, sb: 1'b1, pin: 8'h99, exp: 8'h42};
        vecs[2] = '{start: 8'h42, sp: 1'b1, sb: 1'b1, pin: 8'h07, exp: 8'h07};
        vecs[3] = '{start: 8'hFF, sp: 1'b0, sb: 1'b0, pin: 8'h55, exp: 8'h00};
        vecs[4] = '{start: 8'hFF, sp: 1'b0, sb: 1'b1, pin: 8'h55, exp: 8'h01};
        vecs[5] = '{start: 8'hFE, sp: 1'b0, sb: 1'b1, pin: 8'h55, exp: 8'h00};
        vecs[6] = '{start: 8'h80, sp: 1'b0, sb: 1'b0, pin: 8'h12, exp: 8'h81};
        vecs[7] = '{start: 8'h33, sp: 1'b1, sb: 1'b0, pin: 8'hF0, exp: 8'hF0};
        vecs[8] = '{start: 8'hC0, sp: 1'b1, sb: 1'b1, pin: 8'hFF, exp: 8'hFF};
        vecs[9] = '{start: 8'h7D, sp: 1'b0, sb: 1'b1, pin: 8'h00, exp: 8'h7F};

        // Reset values and sequential fetch: exec_valid in cycles 3, 6, 9.
        do_reset(1'b1);
        for (int c = 1; c <= 9; c++) begin
            if (c > 1) @(negedge clk);
            chk("seq_exec_valid", 32'(exec_valid), 32'((c % 3) == 0));
            if ((c % 3) == 0) begin
                chk("seq_pc", 32'(pc), 32'(c / 3 - 1));
                chk("seq_opcode", 32'(opcode), 32'(rom[c / 3 - 1][11:8]));
                chk("seq_k", 32'(k), 32'(rom[c / 3 - 1][7:0]));
            end
        end

        // Next-PC table: jump, skip, priority and modulo-256 wrap.
        for (int v = 0; v < 10; v++) begin
            goto_pc(vecs[v].start);
            wait_exec();
            chk("tbl_pc", 32'(pc), 32'(vecs[v].start));
            chk("tbl_k", 32'(k), 32'(vecs[v].start));
            sel_pc = vecs[v].sp;
            sel_br = vecs[v].sb;
            pc_in  = vecs[v].pin;
            @(negedge clk);
            sel_pc = 1'b0; sel_br = 1'b0; pc_in = 8'h00;
            chk("tbl_next_rom_addr", 32'(rom_addr), 32'(vecs[v].exp));
            chk("tbl_next_exec_valid", 32'(exec_valid), 32'h0);
        end

        // Run dropped during LOAD at PC 5: instruction completes, then FETCH holds.
        goto_pc(8'h05);
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        chk("stall_exec_valid", 32'(exec_valid), 32'h1);
        chk("stall_exec_pc", 32'(pc), 32'h05);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_idle_exec_valid", 32'(exec_valid), 32'h0);
            chk("stall_idle_pc", 32'(pc), 32'h06);
        end
        run = 1'b1;
        @(negedge clk);
        chk("stall_resume_load", 32'(exec_valid), 32'h0);
        @(negedge clk);
        chk("stall_resume_exec", 32'(exec_valid), 32'h1);
        chk("stall_resume_pc", 32'(pc), 32'h06);

        // Reset asserted during EXEC at PC 0x23.
        goto_pc(8'h23);
        wait_exec();
        chk("midrst_pc_before", 32'(pc), 32'h23);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_pc", 32'(pc), 32'h00);
        chk("midrst_exec_valid", 32'(exec_valid), 32'h0);
        chk("midrst_opcode", 32'(opcode), 32'h0);
        chk("midrst_k", 32'(k), 32'h00);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_load", 32'(exec_valid), 32'h0);
        @(negedge clk);
        chk("midrst_exec", 32'(exec_valid), 32'h1);
        chk("midrst_exec_pc", 32'(pc), 32'h00);

        // Jump-to-self at PC 9.
        goto_pc(8'h09);
`ifdef FETCH_HALT_DETECT_EN
        wait_exec();
        chk("halt_opcode", 32'(opcode), 32'h6);
        sel_pc = 1'b1; pc_in = 8'h09;
        @(negedge clk);
        sel_pc = 1'b0; pc_in = 8'h00;
        for (int i = 0; i < 22; i++) begin
            run = 1'($urandom_range(0, 1));
            chk("halt_halted", 32'(halted), 32'h1);
            chk("halt_exec_valid", 32'(exec_valid), 32'h0);
            chk("halt_pc", 32'(pc), 32'h09);
            chk("halt_rom_addr", 32'(rom_addr), 32'h09);
            @(negedge clk);
        end
        run = 1'b1;
`else
        for (int c = 1; c <= 9; c++) begin
            if (c > 1) @(negedge clk);
            ev = ((c % 3) == 0);
            chk("selfloop_exec_valid", 32'(exec_valid), 32'(ev));
            chk("selfloop_pc", 32'(pc), 32'h09);
            chk("selfloop_halted", 32'(halted), 32'h0);
            sel_pc = ev;
            pc_in  = ev ? 8'h09 : 8'h00;
        end
        sel_pc = 1'b0; pc_in = 8'h00;
`endif

        // Randomized program against an instruction-level model (run held high).
        for (int i = 0; i < 256; i++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'h6) op = 4'h7;
            rom[i] = {op, 8'($urandom)};
        end
        model_pc = 8'h00;
        run = 1'b1;
        do_reset(1'b0);
        for (int c = 1; c <= 600; c++) begin
            if (c > 1) @(negedge clk);
            ev = ((c % 3) == 0);
            chk("rnd_pc", 32'(pc), 32'(model_pc));
            chk("rnd_rom_addr", 32'(rom_addr), 32'(model_pc));
            chk("rnd_exec_valid", 32'(exec_valid), 32'(ev));
            chk("rnd_halted", 32'(halted), 32'h0);
            r = $urandom;
            sel_pc = r[0];
            sel_br = r[1];
            pc_in  = r[15:8];
            if (ev) begin
                chk("rnd_opcode", 32'(opcode), 32'(rom[model_pc][11:8]));
                chk("rnd_k", 32'(k), 32'(rom[model_pc][7:0]));
                if (r[0])      nxt = r[15:8];
                else if (r[1]) nxt = 8'((32'(model_pc) + 2) % 256);
                else           nxt = 8'((32'(model_pc) + 1) % 256);
                model_pc = nxt;
            end
        end
        sel_pc = 1'b0; sel_br = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch and program-counter stage of the 8-bit CPU, directly upstream of the control unit. It owns the PC, addresses the synchronous program ROM, and latches each 12-bit instruction into an instruction register. It presents `opcode`/`k` to the control unit and consumes its `sel_pc`, `sel_br` and `pc_in` outputs to compute the next PC. It issues one `exec_valid` cycle per instruction; the datapath uses that cycle to qualify RAM and accumulator writes.

## Interface
- `RESET_PC`, 8'h00, PC value loaded on reset.
- `INSTR_W`, 12, ROM word width; fixed split `[11:8]` opcode, `[7:0]` K.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `run` in 1: fetch enable; when low, no new instruction is started.
- `rom_data` in `INSTR_W`: ROM read data, valid one cycle after `rom_addr`.
- `sel_pc` in 1: from control unit; 1 = jump to `pc_in`.
- `sel_br` in 1: from control unit; 1 = skip next instruction.
- `pc_in` in 8: jump target from control unit.
- `rom_addr` out 8: ROM read address.
- `opcode` out 4: IR[11:8] to control unit.
- `k` out 8: IR[7:0] to control unit.
- `pc` out 8: address of the instruction in the IR.
- `exec_valid` out 1: high for exactly the execute cycle of each instruction.
- `halted` out 1: sticky halt indicator (see Configuration).

## Operation
- FSM states: FETCH, LOAD, EXEC, and HALT (HALT exists only with the macro).
- **FETCH**
  - `rom_addr` = `pc`.
  - If `run`=1, go to LOAD; else stay in FETCH.
- **LOAD**
  - IR <= `rom_data`; go to EXEC.
- **EXEC**
  - `exec_valid`=1; the control unit decodes IR combinationally.
  - Next PC priority, all 8-bit modulo 256:
    - `sel_pc`=1: `pc_in`.
    - else `sel_br`=1: `pc`+2.
    - else: `pc`+1.
  - `sel_pc` and `sel_br` both high: jump wins.
  - PC is updated on the EXEC→FETCH edge; go to FETCH.
- **`run` behaviour**
  - `run` is sampled only in FETCH.
  - Dropping `run` during LOAD/EXEC completes the current instruction, then the FSM holds in FETCH.
- **Wrap examples**
  - PC 8'hFF increment → 8'h00.
  - PC 8'hFF skip → 8'h01.
  - PC 8'hFE skip → 8'h00.
- **IR and outputs**
  - IR and `opcode`/`k` hold their value outside LOAD.
  - `sel_pc`/`sel_br`/`pc_in` are ignored outside EXEC.

## Timing
- **Reset values** (all outputs are registered or state-derived):
  - `pc`=`RESET_PC`, `rom_addr`=`RESET_PC`.
  - `opcode`=4'h0, `k`=8'h00.
  - `exec_valid`=0, `halted`=0.
  - state = FETCH.
- **Throughput:** 3 cycles per instruction with `run` held high. `exec_valid` pattern: 0,0,1 repeating, first high in the 3rd cycle after `rst` deasserts.
- **Latency:** `rom_addr` is presented in FETCH; `rom_data` is captured at the end of LOAD; `opcode`/`k` are valid throughout EXEC.
- **Reset mid-instruction:** `rst` in any state forces reset values on the next edge. An in-flight instruction is abandoned; no `exec_valid` pulse is generated for it.
- **Downstream write qualification:** downstream writes must be qualified by `exec_valid`. The fetch unit never asserts `exec_valid` for two consecutive cycles.

## Configuration
- Macro: `FETCH_HALT_DETECT_EN`.
- **Defined:**
  - In EXEC, `opcode`=4'b0110 with `k`==`pc` (jump-to-self) → next state HALT, `halted`<=1, `pc` unchanged.
  - HALT: `exec_valid`=0; no ROM fetches; `rom_addr` holds `pc`; `run` is ignored.
  - Only `rst` leaves HALT.
- **Not defined:**
  - HALT state is absent and `halted` is tied to 0.
  - Jump-to-self loops normally at 3 cycles per iteration.

## Test plan
- Sequential fetch: ROM[0..2] = 12'hF05, 12'h103, 12'h502, `sel_*`=0 → `exec_valid` in cycles 3, 6, 9. `opcode`/`k` are F/05, 1/03, 5/02; `pc` is 0, 1, 2.
- Jump and skip: EXEC at PC 8'h10 with `sel_pc`=1, `pc_in`=8'h40 → next `rom_addr`=8'h40. EXEC at PC 8'h40 with `sel_br`=1 → next `rom_addr`=8'h42. Both selects high at 8'h42 with `pc_in`=8'h07 → next `rom_addr`=8'h07.
- Wrap: PC 8'hFF increment → 8'h00; PC 8'hFF skip → 8'h01; PC 8'hFE skip → 8'h00.
- Run stall: drop `run` during LOAD at PC 5 → EXEC completes, `pc` becomes 6, FSM holds in FETCH with no `exec_valid` for 10 cycles. Raise `run` → instruction 6 executes 3 cycles later.
- Reset mid-op: assert `rst` during EXEC at PC 8'h23 → next cycle `pc`=8'h00, `exec_valid`=0, `opcode`=0, `k`=0, state FETCH.
- Halt (macro defined): ROM[8'h09]=12'h609 → after its EXEC, `halted`=1 and `exec_valid` stays 0 for 20+ cycles. Without the macro, `exec_valid` pulses every 3 cycles with `pc`=8'h09.
